// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch unit, instruction memory and the consumer.
// Handshakes: imem_req is a one-cycle request pulse answered by a later
// one-cycle imem_rvalid pulse; instr_valid/instr_ready transfer the head
// entry on any rising edge where both are high, and instr_valid never
// depends on instr_ready.
interface fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;

   // Fetch unit side
   modport master (
      output imem_req, imem_addr, instr_valid, instr, instr_pc,
      input  imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
   );

   // Environment side (memory, redirect source, consumer)
   modport slave (
      input  imem_req, imem_addr, instr_valid, instr, instr_pc,
      output imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one outstanding memory read at a time,
// buffers returned words with their fetch address in a small FIFO and
// restarts fetch on redirect, discarding any in-flight response.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic         clk,
   input  logic         reset,
   fetch_unit_if.master bus,
   output logic [1:0]   dbg_state
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   req_pc_q, req_pc_d;
   logic [31:0]   buf_instr_q [DEPTH];
   logic [31:0]   buf_instr_d [DEPTH];
   logic [31:0]   buf_pc_q [DEPTH];
   logic [31:0]   buf_pc_d [DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;

   logic req;
   logic push;
   logic pop;
   logic full;
   logic valid;

   // Next-state logic: redirect overrides everything, otherwise the FSM
   // issues/collects one request while the FIFO pushes and pops.
   always_comb begin
      state_d     = state_q;
      fetch_pc_d  = fetch_pc_q;
      req_pc_d    = req_pc_q;
      buf_instr_d = buf_instr_q;
      buf_pc_d    = buf_pc_q;
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      count_d     = count_q;
      req         = 1'b0;
      push        = 1'b0;
      full        = (count_q == CW'(DEPTH));
      valid       = (count_q != '0) && !bus.redirect && reset;
      pop         = valid && bus.instr_ready;

      if (bus.redirect) begin
         // Flush and retarget; an in-flight response must still be absorbed.
         fetch_pc_d = bus.redirect_pc;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
         case (state_q)
            IDLE:    state_d = IDLE;
            WAIT:    state_d = bus.imem_rvalid ? IDLE : DROP;
            DROP:    state_d = bus.imem_rvalid ? IDLE : DROP;
            default: state_d = IDLE;
         endcase
      end else begin
         case (state_q)
            IDLE: begin
               if (!full) begin
                  req        = 1'b1;
                  req_pc_d   = fetch_pc_q;
                  fetch_pc_d = fetch_pc_q + 32'd4;
                  state_d    = WAIT;
               end
            end
            WAIT: begin
               if (bus.imem_rvalid) begin
                  push    = 1'b1;
                  state_d = IDLE;
               end
            end
            DROP: begin
               if (bus.imem_rvalid) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase

         if (push) begin
            buf_instr_d[wr_ptr_q] = bus.imem_rdata;
            buf_pc_d[wr_ptr_q]    = req_pc_q;
            wr_ptr_d              = wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // State and FIFO registers; reset forgets any outstanding request.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC;
         req_pc_q   <= RESET_PC;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            buf_instr_q[i] <= '0;
            buf_pc_q[i]    <= '0;
         end
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         req_pc_q    <= req_pc_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         buf_instr_q <= buf_instr_d;
         buf_pc_q    <= buf_pc_d;
      end
   end

   // Request is gated by reset so nothing issues while reset is held.
   assign bus.imem_req    = req && reset;
   assign bus.imem_addr   = fetch_pc_q;
   assign bus.instr_valid = valid;
   assign bus.instr       = buf_instr_q[rd_ptr_q];
   assign bus.instr_pc    = buf_pc_q[rd_ptr_q];
   assign dbg_state       = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a memory responder with variable latency, a
// consumer and redirect source, and a transaction-level reference model
// (expected request address stream plus a queue of expected delivered PCs).
module tb_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          DEPTH    = 2;

   logic       clk;
   logic       reset_n;
   logic [1:0] dbg_state;

   fetch_unit_if bus_if ();

   fetch_unit #(
      .RESET_PC (RESET_PC),
      .DEPTH    (DEPTH)
   ) dut (
      .clk       (clk),
      .reset     (reset_n),
      .bus       (bus_if),
      .dbg_state (dbg_state)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   logic [31:0] exp_q[$];        // PCs expected at the consumer, in order
   logic [31:0] req_pc_m;        // next expected request address
   bit          pend;            // memory holds an outstanding request
   int          pend_cnt;
   logic [31:0] pend_addr;
   logic [31:0] pend_exp_pc;
   bit          pend_drop;
   bit          resp_now;
   bit          resp_drop;
   logic [31:0] resp_exp_pc;
   bit          spur_en;
   int          lat_lo;
   int          lat_hi;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Compare DUT outputs with the model for the current cycle, then advance the model.
   task automatic monitor();
      logic        exp_req;
      logic        exp_valid;
      logic [31:0] p;
      if (!reset_n) begin
         check_eq("rst_req", {31'b0, bus_if.imem_req}, 32'd0);
         check_eq("rst_valid", {31'b0, bus_if.instr_valid}, 32'd0);
         exp_q.delete();
         req_pc_m  = RESET_PC;
         pend_drop = 1'b1;
         return;
      end
      exp_req   = !bus_if.redirect && !pend && !resp_now && (exp_q.size() < DEPTH);
      exp_valid = (exp_q.size() != 0) && !bus_if.redirect;
      check_eq("req", {31'b0, bus_if.imem_req}, {31'b0, exp_req});
      check_eq("valid", {31'b0, bus_if.instr_valid}, {31'b0, exp_valid});
      if (bus_if.imem_req) begin
         check_eq("addr", bus_if.imem_addr, req_pc_m);
         check_eq("one_outstanding", {31'b0, pend}, 32'd0);
         pend        = 1'b1;
         pend_cnt    = $urandom_range(lat_hi, lat_lo);
         pend_addr   = bus_if.imem_addr;
         pend_exp_pc = req_pc_m;
         pend_drop   = 1'b0;
         req_pc_m    = req_pc_m + 32'd4;
      end
      if (exp_valid && bus_if.instr_ready) begin
         p = exp_q.pop_front();
         check_eq("instr_pc", bus_if.instr_pc, p);
         check_eq("instr", bus_if.instr, mem_word(p));
      end
      if (bus_if.redirect) begin
         exp_q.delete();
         req_pc_m = bus_if.redirect_pc;
         if (pend) pend_drop = 1'b1;
      end else if (resp_now && !resp_drop) begin
         exp_q.push_back(resp_exp_pc);
      end
   endtask

   // One clock cycle: drive memory response, check at negedge, advance to posedge+1.
   task automatic step();
      resp_now = 1'b0;
      bus_if.imem_rvalid = 1'b0;
      if (pend) begin
         if (pend_cnt <= 1) begin
            resp_now              = 1'b1;
            resp_drop             = pend_drop;
            resp_exp_pc           = pend_exp_pc;
            bus_if.imem_rvalid    = 1'b1;
            bus_if.imem_rdata     = mem_word(pend_addr);
            pend                  = 1'b0;
         end else begin
            pend_cnt--;
         end
      end else if (spur_en && $urandom_range(3, 0) == 0) begin
         bus_if.imem_rvalid = 1'b1;
         bus_if.imem_rdata  = $urandom;
      end
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_redirect(input logic [31:0] pc);
      bus_if.redirect    = 1'b1;
      bus_if.redirect_pc = pc;
      step();
      bus_if.redirect    = 1'b0;
   endtask

   initial begin
      bus_if.imem_rvalid = 1'b0;
      bus_if.imem_rdata  = '0;
      bus_if.redirect    = 1'b0;
      bus_if.redirect_pc = '0;
      bus_if.instr_ready = 1'b1;
      reset_n  = 1'b0;
      pend     = 1'b0;
      pend_cnt = 0;
      pend_drop = 1'b0;
      resp_now = 1'b0;
      resp_drop = 1'b0;
      spur_en  = 1'b0;
      lat_lo   = 1;
      lat_hi   = 1;
      req_pc_m = RESET_PC;
      @(posedge clk);
      #1;
      run(3);
      check_eq("rst_state", {30'b0, dbg_state}, 32'd0);
      reset_n = 1'b1;

      // Straight-line fetch, 1-cycle memory, always-ready consumer
      run(8);

      // Stalled consumer fills the buffer; a single pop allows one more request
      bus_if.instr_ready = 1'b0;
      run(8);
      bus_if.instr_ready = 1'b1;
      step();
      bus_if.instr_ready = 1'b0;
      run(6);
      bus_if.instr_ready = 1'b1;
      run(6);

      // Redirect while a slow response is outstanding
      lat_lo = 3;
      lat_hi = 3;
      for (int k = 0; k < 20 && !pend; k++) step();
      check_eq("wait_pend_a", {31'b0, pend}, 32'd1);
      do_redirect(32'h0000_0100);
      run(12);

      // Redirect coinciding with a response and a consumer handshake
      lat_lo = 2;
      lat_hi = 2;
      bus_if.instr_ready = 1'b0;
      for (int k = 0; k < 30 && !(exp_q.size() >= 1 && pend && pend_cnt == 1); k++) step();
      check_eq("wait_pend_b", {31'b0, pend}, 32'd1);
      bus_if.instr_ready = 1'b1;
      do_redirect(32'h0000_0200);
      run(8);

      // Address wrap past the top of memory
      lat_lo = 1;
      lat_hi = 1;
      for (int k = 0; k < 20 && pend; k++) step();
      do_redirect(32'hFFFF_FFFC);
      run(8);

      // Reset asserted mid-wait with one buffered entry
      lat_lo = 3;
      lat_hi = 3;
      bus_if.instr_ready = 1'b0;
      for (int k = 0; k < 30 && !(exp_q.size() == 1 && pend); k++) step();
      check_eq("wait_pend_c", {31'b0, pend}, 32'd1);
      reset_n = 1'b0;
      #1;
      check_eq("async_req", {31'b0, bus_if.imem_req}, 32'd0);
      check_eq("async_valid", {31'b0, bus_if.instr_valid}, 32'd0);
      run(5);
      check_eq("late_resp_gone", {31'b0, pend}, 32'd0);
      pend = 1'b0;
      reset_n = 1'b1;
      bus_if.instr_ready = 1'b1;
      lat_lo = 1;
      lat_hi = 1;
      run(10);

      // Randomized traffic
      spur_en = 1'b1;
      lat_lo  = 1;
      lat_hi  = 3;
      for (int i = 0; i < 800; i++) begin
         bus_if.instr_ready = ($urandom_range(3, 0) != 0);
         if ($urandom_range(19, 0) == 0) begin
            bus_if.redirect    = 1'b1;
            bus_if.redirect_pc = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF8
                                                             : ($urandom & 32'h0000_FFFC);
         end else begin
            bus_if.redirect    = 1'b0;
            bus_if.redirect_pc = $urandom;
         end
         step();
      end
      bus_if.redirect    = 1'b0;
      bus_if.instr_ready = 1'b1;
      spur_en = 1'b0;
      run(20);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 The module SHALL have parameter DEPTH, default 2, giving the instruction-buffer entry count (power of two, >=2).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 imem_req  output  1  instruction-memory read request, one-cycle pulse per request.
REQ-006 imem_addr  output  32  read address; valid when imem_req=1.
REQ-007 imem_rvalid  input  1  read data valid, one-cycle pulse, at least 1 cycle after imem_req.
REQ-008 imem_rdata  input  32  read data; valid when imem_rvalid=1.
REQ-009 redirect  input  1  one-cycle request to restart fetch at redirect_pc.
REQ-010 redirect_pc  input  32  new fetch address; sampled when redirect=1.
REQ-011 instr_valid  output  1  buffer head holds a valid instruction.
REQ-012 instr_ready  input  1  consumer accepts the head entry this cycle.
REQ-013 instr  output  32  head-entry instruction word.
REQ-014 instr_pc  output  32  address from which instr was fetched.

Function
REQ-015 The module SHALL keep fetch_pc, a DEPTH-entry FIFO of {instr, pc}, an entry count 0..DEPTH, and a state machine with states IDLE, WAIT and DROP.
REQ-016 In IDLE with count<DEPTH and redirect=0, the module SHALL assert imem_req=1 and imem_addr=fetch_pc combinationally, latch req_pc=fetch_pc, set fetch_pc=fetch_pc+4 modulo 2^32 (32'hFFFF_FFFC wraps to 0), and go to WAIT.
REQ-017 In IDLE with count=DEPTH, imem_req SHALL stay 0 and the state SHALL remain IDLE.
REQ-018 At most one request SHALL be outstanding; imem_req SHALL be 0 in WAIT and DROP.
REQ-019 In WAIT with imem_rvalid=1 and redirect=0, the module SHALL push {imem_rdata, req_pc} and go to IDLE; the next request SHALL issue no earlier than the following cycle.
REQ-020 imem_rvalid arriving in IDLE SHALL be ignored.
REQ-021 instr_valid SHALL be (count!=0) AND NOT redirect; instr and instr_pc SHALL show the head entry, and are don't-care when instr_valid=0.
REQ-022 A pop SHALL occur when instr_valid=1 and instr_ready=1; a push and pop in the same cycle SHALL leave count unchanged and preserve order.
REQ-023 redirect=1 SHALL have top priority: flush the FIFO (count=0), set fetch_pc=redirect_pc, and suppress any push, pop or request that cycle.
REQ-024 Redirect in IDLE SHALL leave the state in IDLE; the first request to redirect_pc SHALL issue in the next cycle.
REQ-025 Redirect in WAIT without imem_rvalid SHALL go to DROP; redirect in WAIT with imem_rvalid SHALL discard that data and go to IDLE.
REQ-026 In DROP, imem_rvalid SHALL be discarded with a move to IDLE; a further redirect in DROP SHALL update fetch_pc and stay in DROP.
REQ-027 The minimum fetch throughput SHALL be one instruction per 2 cycles with 1-cycle memory latency.

Reset
REQ-028 While reset=0, the module SHALL hold state IDLE, fetch_pc=RESET_PC, count=0, imem_req=0 and instr_valid=0; an outstanding request SHALL be forgotten.
REQ-029 After reset rises, the module SHALL issue the first request (imem_addr=RESET_PC) in the first cycle.

Verification
REQ-030 Reset release, 1-cycle memory, instr_ready=1 -> requests 0x0, 0x4, 0x8 on alternating cycles; instr_pc sequence 0x0, 0x4, 0x8 with matching data.
REQ-031 instr_ready=0, DEPTH=2 -> two entries buffered, then imem_req stays 0; one pop -> exactly one new request issues.
REQ-032 Redirect to 0x100 while WAIT, response 3 cycles later -> response dropped, FIFO empty, next request addr 0x100, instr_pc=0x100 delivered.
REQ-033 Redirect in the same cycle as imem_rvalid and a valid/ready handshake -> no pop, no push, instr_valid=0 that cycle, next request at redirect_pc.
REQ-034 Redirect to 0xFFFF_FFFC -> requests 0xFFFF_FFFC then 0x0000_0000.
REQ-035 reset=0 asserted mid-WAIT with FIFO holding 1 entry -> outputs cleared immediately; late imem_rvalid ignored; fetch restarts at RESET_PC.
